pc_gen: RTL and testbench

- Parametrised program-counter generator for the fetch stage.
- Owns the fetch PC and a direct-mapped branch target buffer (BTB) that predicts taken branches.
- Arbitrates redirects from EX and ID, and holds any redirect that arrives during a backend stall until the stall releases.
- Drives the fetch address and a registered predicted-taken flag, which travels with the instruction.

---
 rtl/pc_gen.sv | 86 ++++++++
 tb/tb_pc_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch program counter with a direct-mapped BTB and a redirect held across backend stalls
module pc_gen #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_hard,
  input  logic              stall_fetch,
  input  logic              ex_redir,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              id_redir,
  input  logic [ADDR_W-1:0] id_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_taken,
  output logic [ADDR_W-1:0] pc_o,
  output logic              pred_taken_o,
  output logic              redir_pending_o
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;
  logic [ADDR_W-1:0] pc_q, pc_n, pend_tgt;
  logic pred_q, pred_n, pend_v, pend_ex, hit, redir, upd_match, unused_lsb;
  logic [BTB_DEPTH-1:0] btb_v;
  logic [TAG_W-1:0] btb_tag [BTB_DEPTH];
  logic [ADDR_W-1:0] btb_tgt [BTB_DEPTH];
  logic [IDX_W-1:0] idx, upd_idx;
  assign idx = pc_q[IDX_W+1:2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign hit = btb_v[idx] && btb_tag[idx] == pc_q[ADDR_W-1:IDX_W+2];
  assign upd_match = btb_tag[upd_idx] == upd_pc[ADDR_W-1:IDX_W+2];
  assign unused_lsb = ^upd_pc[1:0];
  assign redir = ex_redir || id_redir || pend_v;
  assign pc_o = pc_q;
  assign pred_taken_o = pred_q;
  assign redir_pending_o = pend_v;
  always_comb begin
    pc_n = stall_hard ? pc_q : ex_redir ? ex_target : id_redir ? id_target :
           pend_v ? pend_tgt : stall_fetch ? pc_q : hit ? btb_tgt[idx] : pc_q + ADDR_W'(4);
    pred_n = (stall_hard || (stall_fetch && !redir)) ? pred_q : !redir && hit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      pred_q <= 1'b0;
    end else begin
      pc_q <= pc_n;
      pred_q <= pred_n;
    end
  end
  // An EX redirect held during a stall must not be displaced by a later, older-path ID redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v <= 1'b0;
      pend_ex <= 1'b0;
      pend_tgt <= '0;
    end else if (stall_hard) begin
      if (ex_redir) begin
        pend_v <= 1'b1;
        pend_ex <= 1'b1;
        pend_tgt <= ex_target;
      end else if (id_redir && !(pend_v && pend_ex)) begin
        pend_v <= 1'b1;
        pend_ex <= 1'b0;
        pend_tgt <= id_target;
      end
    end else begin
      pend_v <= 1'b0;
      pend_ex <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) btb_v <= '0;
    else if (upd_valid && upd_taken) btb_v[upd_idx] <= 1'b1;
    else if (upd_valid && upd_match) btb_v[upd_idx] <= 1'b0;
  end
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_tag[upd_idx] <= upd_pc[ADDR_W-1:IDX_W+2];
      btb_tgt[upd_idx] <= upd_target;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table plus randomized run against a slot-per-branch BTB model
module tb_pc_gen;
  logic clk = 0, rst, stall_hard, stall_fetch, ex_redir, id_redir, upd_valid, upd_taken;
  logic [31:0] ex_target, id_target, upd_pc, upd_target, pc_o;
  logic pred_taken_o, redir_pending_o;
  int total = 0, passed = 0;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall_hard(stall_hard), .stall_fetch(stall_fetch),
    .ex_redir(ex_redir), .ex_target(ex_target), .id_redir(id_redir), .id_target(id_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .pc_o(pc_o), .pred_taken_o(pred_taken_o), .redir_pending_o(redir_pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, sh, sf, ex;
    logic [31:0] ext;
    logic id;
    logic [31:0] idt;
    logic uv;
    logic [31:0] upc, utg;
    logic utk;
    logic [31:0] epc;
    logic ep, epd;
  } vec_t;

  typedef struct {
    logic [31:0] pc, tgt;
  } ent_t;

  vec_t tbl[$];
  ent_t m_btb[int];
  logic [32:0] m_pend[$];
  logic [31:0] m_pc;
  logic m_pred;

  function automatic vec_t v(input logic r, sh, sf, ex, input logic [31:0] ext, input logic id,
                             input logic [31:0] idt, input logic uv, input logic [31:0] upc, utg,
                             input logic utk, input logic [31:0] epc, input logic ep, epd);
    vec_t t;
    t = '{r, sh, sf, ex, ext, id, idt, uv, upc, utg, utk, epc, ep, epd};
    return t;
  endfunction

  task chk(input string name, input logic [31:0] act, exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task drive(input vec_t t);
    rst = t.r; stall_hard = t.sh; stall_fetch = t.sf;
    ex_redir = t.ex; ex_target = t.ext; id_redir = t.id; id_target = t.idt;
    upd_valid = t.uv; upd_pc = t.upc; upd_target = t.utg; upd_taken = t.utk;
  endtask

  // The BTB remembers, per slot, the last taken branch PC and its target; it predicts
  // only when the current word address is exactly that branch.
  task model_step();
    int i, j;
    bit hit;
    i = int'((m_pc >> 2) % 16);
    hit = 0;
    if (m_btb.exists(i)) hit = (m_btb[i].pc >> 2) == (m_pc >> 2);
    if (rst) begin
      m_pc = 0; m_pred = 0; m_pend.delete(); m_btb.delete();
    end else begin
      if (stall_hard) begin
        if (ex_redir) begin
          m_pend.delete(); m_pend.push_back({1'b1, ex_target});
        end else if (id_redir && !(m_pend.size() > 0 && m_pend[0][32])) begin
          m_pend.delete(); m_pend.push_back({1'b0, id_target});
        end
      end else if (ex_redir || id_redir || m_pend.size() > 0) begin
        m_pc = ex_redir ? ex_target : id_redir ? id_target : m_pend[0][31:0];
        m_pred = 0;
        m_pend.delete();
      end else if (!stall_fetch) begin
        m_pred = hit;
        m_pc = hit ? m_btb[i].tgt : m_pc + 4;
      end
      if (upd_valid) begin
        j = int'((upd_pc >> 2) % 16);
        if (upd_taken) m_btb[j] = '{upd_pc, upd_target};
        else if (m_btb.exists(j)) if ((m_btb[j].pc >> 2) == (upd_pc >> 2)) m_btb.delete(j);
      end
    end
  endtask

  function automatic logic [31:0] rtgt();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  initial begin
    vec_t t;
    // r sh sf ex ext id idt uv upc utg utk | epc ep epd
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0, 32'h0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h4,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h8,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'hC,0,0));
    tbl.push_back(v(0,0,0,1,32'h0,0,0,1,32'h10,32'h80,1, 32'h0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h4,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h8,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'hC,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h10,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h80,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h84,0,0));
    tbl.push_back(v(0,0,0,1,32'h10,0,0,1,32'h10,32'h80,0, 32'h10,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h14,0,0));
    tbl.push_back(v(0,1,0,0,0,1,32'h200,0,0,0,0, 32'h14,0,1));
    tbl.push_back(v(0,1,0,1,32'h300,0,0,0,0,0,0, 32'h14,0,1));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 32'h14,0,1));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h300,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h304,0,0));
    tbl.push_back(v(0,0,1,1,32'h40,1,32'h50,0,0,0,0, 32'h40,0,0));
    tbl.push_back(v(0,0,1,0,0,0,0,0,0,0,0, 32'h40,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h44,0,0));
    tbl.push_back(v(0,0,0,1,32'hC,0,0,1,32'h10,32'h80,1, 32'hC,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,32'h50,32'h90,1, 32'h10,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h14,0,0));
    tbl.push_back(v(0,0,0,1,32'h4C,0,0,0,0,0,0, 32'h4C,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h50,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h90,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h94,0,0));
    tbl.push_back(v(0,1,0,0,0,1,32'h100,0,0,0,0, 32'h94,0,1));
    tbl.push_back(v(0,0,0,0,0,1,32'h120,0,0,0,0, 32'h120,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h124,0,0));
    tbl.push_back(v(0,1,0,1,32'h400,0,0,0,0,0,0, 32'h124,0,1));
    tbl.push_back(v(0,1,0,0,0,1,32'h500,0,0,0,0, 32'h124,0,1));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h400,0,0));
    tbl.push_back(v(0,0,0,1,32'h20,0,0,0,0,0,0, 32'h20,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,32'h20,32'hA0,1, 32'h24,0,0));
    tbl.push_back(v(0,0,0,1,32'h20,0,0,0,0,0,0, 32'h20,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'hA0,1,0));
    tbl.push_back(v(0,1,0,0,0,0,0,0,0,0,0, 32'hA0,1,0));
    tbl.push_back(v(0,0,1,0,0,0,0,0,0,0,0, 32'hA0,1,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'hA4,0,0));
    tbl.push_back(v(0,0,0,1,32'hFFFFFFFC,0,0,0,0,0,0, 32'hFFFFFFFC,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h4,0,0));
    tbl.push_back(v(0,1,0,1,32'h700,0,0,0,0,0,0, 32'h4,0,1));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,0,0, 32'h0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h4,0,0));
    tbl.push_back(v(0,0,0,1,32'h20,0,0,0,0,0,0, 32'h20,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0, 32'h24,0,0));
    drive(tbl[0]);
    #1;
    foreach (tbl[k]) begin
      drive(tbl[k]);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pc", k), pc_o, tbl[k].epc);
      chk($sformatf("vec%0d pred", k), 32'(pred_taken_o), 32'(tbl[k].ep));
      chk($sformatf("vec%0d pend", k), 32'(redir_pending_o), 32'(tbl[k].epd));
    end
    for (int n = 0; n < 3000; n++) begin
      t = v(n == 0 || $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8, rtgt(),
            $urandom_range(0, 99) < 8, rtgt(), $urandom_range(0, 99) < 35,
            ($urandom_range(0, 3) == 0 ? ($urandom & 32'hFFFFF000) : 32'h0) | 32'($urandom_range(0, 1023)),
            rtgt(), $urandom_range(0, 99) < 70, 0, 0, 0);
      drive(t);
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d pc", n), pc_o, m_pc);
      chk($sformatf("rnd%0d pred", n), 32'(pred_taken_o), 32'(m_pred));
      chk($sformatf("rnd%0d pend", n), 32'(redir_pending_o), 32'(m_pend.size() != 0));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
